// File: rtl/ifu_tag_ctrl.sv
// Fully associative tag controller for the fetch unit: tag lookup, PLRU handshake and line refill.
// Defining IFU_TAG_CTRL_FLUSH_EN adds a flush input that invalidates every line.
package ifu_tag_ctrl_pkg;
    localparam int unsigned WAYS_NUM = 16;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned WAY_W    = $clog2(WAYS_NUM);
    localparam int unsigned TAG_W    = ADDR_W - OFFSET_W;

    typedef struct packed {
        logic             update_tree;
        logic             cache_miss;
        logic [WAY_W-1:0] hit_cl;
    } t_cache_ctrl_plru;
endpackage

module ifu_tag_ctrl
    import ifu_tag_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
`ifdef IFU_TAG_CTRL_FLUSH_EN
    input  logic              flush,
`endif
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [WAY_W-1:0]  rsp_way,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    output logic              fill_en,
    output logic [WAY_W-1:0]  fill_way,
    output t_cache_ctrl_plru  cache_ctrl_plru,
    input  logic [WAY_W-1:0]  evicted_cl
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } state_e;

    state_e              state_q, state_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WAYS_NUM-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]    tags_q [WAYS_NUM];
    logic [TAG_W-1:0]    tags_d [WAYS_NUM];
    logic                flush_pend_q, flush_pend_d;
    logic                flush_in_c;

`ifdef IFU_TAG_CTRL_FLUSH_EN
    assign flush_in_c = flush;
`else
    assign flush_in_c = 1'b0;
`endif

    // Parallel tag compare; at most one way can match, so OR-ing indices encodes it.
    logic [WAYS_NUM-1:0] match_c;
    logic                hit_c;
    logic [WAY_W-1:0]    hit_way_c;

    always_comb begin
        match_c   = '0;
        hit_way_c = '0;
        for (int unsigned i = 0; i < WAYS_NUM; i++) begin
            match_c[i] = valid_q[i] && (tags_q[i] == req_tag_q);
            if (match_c[i]) begin
                hit_way_c = hit_way_c | WAY_W'(i);
            end
        end
        hit_c = |match_c;
    end

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        req_tag_d       = req_tag_q;
        victim_d        = victim_q;
        valid_d         = valid_q;
        tags_d          = tags_q;
        flush_pend_d    = flush_pend_q;
        req_ready       = 1'b0;
        rsp_valid       = 1'b0;
        rsp_way         = '0;
        mem_req_valid   = 1'b0;
        mem_req_addr    = '0;
        fill_en         = 1'b0;
        fill_way        = '0;
        cache_ctrl_plru = '0;

        if (flush_in_c && (state_q != IDLE)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                // A new or deferred flush takes the cycle; no request is accepted alongside it.
                if (flush_in_c || flush_pend_q) begin
                    valid_d      = '0;
                    flush_pend_d = 1'b0;
                end else begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        req_tag_d = req_addr[ADDR_W-1:OFFSET_W];
                        state_d   = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                cache_ctrl_plru.update_tree = 1'b1;
                if (hit_c) begin
                    rsp_valid              = 1'b1;
                    rsp_way                = hit_way_c;
                    cache_ctrl_plru.hit_cl = hit_way_c;
                    state_d                = IDLE;
                end else begin
                    cache_ctrl_plru.cache_miss = 1'b1;
                    victim_d                   = evicted_cl;
                    valid_d[evicted_cl]        = 1'b0;
                    state_d                    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {req_tag_q, {OFFSET_W{1'b0}}};
                if (mem_req_ready) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (mem_rsp_valid) begin
                    fill_en           = 1'b1;
                    fill_way          = victim_q;
                    tags_d[victim_q]  = req_tag_q;
                    valid_d[victim_q] = 1'b1;
                    state_d           = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                rsp_way   = victim_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            req_tag_q    <= '0;
            victim_q     <= '0;
            valid_q      <= '0;
            tags_q       <= '{default: '0};
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_tag_q    <= req_tag_d;
            victim_q     <= victim_d;
            valid_q      <= valid_d;
            tags_q       <= tags_d;
            flush_pend_q <= flush_pend_d;
        end
    end

endmodule

// File: tb/tb_ifu_tag_ctrl.sv
// Self-checking bench for ifu_tag_ctrl: vector table of fetches, response scoreboard, reset/flush corners.
// Build with IFU_TAG_CTRL_FLUSH_EN defined to exercise the flush cases.
module tb_ifu_tag_ctrl;
    import ifu_tag_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic              req_ready;
    logic              rsp_valid;
    logic [WAY_W-1:0]  rsp_way;
    logic              mem_req_valid;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_ready = 1'b0;
    logic              mem_rsp_valid = 1'b0;
    logic              fill_en;
    logic [WAY_W-1:0]  fill_way;
    t_cache_ctrl_plru  plru;
    logic [WAY_W-1:0]  evicted_cl = '0;
`ifdef IFU_TAG_CTRL_FLUSH_EN
    logic              flush = 1'b0;
`endif

    ifu_tag_ctrl dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IFU_TAG_CTRL_FLUSH_EN
        .flush          (flush),
`endif
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_way        (rsp_way),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .fill_en        (fill_en),
        .fill_way       (fill_way),
        .cache_ctrl_plru(plru),
        .evicted_cl     (evicted_cl)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected response way pushed at accept, popped when rsp_valid appears.
    logic [WAY_W-1:0] sb_q[$];
    logic [WAY_W-1:0] sb_exp;

    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("rsp_way", 32'(rsp_way), 32'(sb_exp));
            end
        end
    end

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [WAY_W-1:0]  evict;
        bit                exp_hit;
        logic [WAY_W-1:0]  exp_way;
        int                stall;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] addr, input int evict, input bit hit, input int way,
                           input int stall);
        vec_t v;
        v.addr    = addr;
        v.evict   = WAY_W'(evict);
        v.exp_hit = hit;
        v.exp_way = WAY_W'(way);
        v.stall   = stall;
        vecs.push_back(v);
    endtask

    // Wait (bounded) for req_ready with req_valid high; returns aligned to posedge+1 in LOOKUP.
    task automatic accept(input logic [31:0] addr, input logic [WAY_W-1:0] evict, output bit ok);
        int k = 0;
        req_valid  = 1'b1;
        req_addr   = addr;
        evicted_cl = evict;
        @(negedge clk);
        while (!req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        ok = req_ready;
        if (!ok) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // One fetch: lookup, and for a miss the refill with optional MISS_REQ stall / MISS_WAIT flush.
    task automatic run_txn(input logic [31:0] addr, input logic [WAY_W-1:0] evict, input bit exp_hit,
                           input logic [WAY_W-1:0] exp_way, input int stall, input bit flush_at_wait);
        bit ok;
        logic [31:0] line;
        line = addr & 32'hFFFF_FFF0;
        accept(addr, evict, ok);
        if (!ok) return;
        sb_q.push_back(exp_way);
        @(negedge clk);
        check("lookup_update_tree", 32'(plru.update_tree), 32'd1);
        check("lookup_cache_miss", 32'(plru.cache_miss), 32'(!exp_hit));
        check("lookup_hit_cl", 32'(plru.hit_cl), exp_hit ? 32'(exp_way) : 32'd0);
        check("lookup_rsp_valid", 32'(rsp_valid), 32'(exp_hit));
        @(posedge clk);
        #1;
        if (exp_hit) return;
        for (int i = 0; i < stall; i++) begin
            mem_rsp_valid = (i == 1);
            @(negedge clk);
            check("stall_mem_req_valid", 32'(mem_req_valid), 32'd1);
            check("stall_mem_req_addr", mem_req_addr, line);
            check("stall_req_ready", 32'(req_ready), 32'd0);
            check("stall_fill_en", 32'(fill_en), 32'd0);
            @(posedge clk);
            #1;
        end
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        check("mem_req_valid", 32'(mem_req_valid), 32'd1);
        check("mem_req_addr", mem_req_addr, line);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        if (flush_at_wait) begin
`ifdef IFU_TAG_CTRL_FLUSH_EN
            flush = 1'b1;
`endif
        end
        @(negedge clk);
        check("wait_fill_en", 32'(fill_en), 32'd0);
        check("wait_mem_req_valid", 32'(mem_req_valid), 32'd0);
        @(posedge clk);
        #1;
`ifdef IFU_TAG_CTRL_FLUSH_EN
        flush = 1'b0;
`endif
        mem_rsp_valid = 1'b1;
        @(negedge clk);
        check("fill_en", 32'(fill_en), 32'd1);
        check("fill_way", 32'(fill_way), 32'(exp_way));
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("resp_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Vector table: first fill/hit, 17 distinct lines with explicit victims, then re-requests.
        add_vec(32'h0000_1000, 0, 1'b0, 0, 0);
        add_vec(32'h0000_1000, 9, 1'b1, 0, 0);
        for (int i = 0; i < 16; i++) begin
            add_vec(32'(i * 16), i, 1'b0, i, (i == 3) ? 5 : 0);
        end
        add_vec(32'h0000_0100, 5, 1'b0, 5, 0);
        add_vec(32'h0000_0100, 0, 1'b1, 5, 0);
        add_vec(32'h0000_0050, 7, 1'b0, 7, 0);
        add_vec(32'h0000_00A0, 0, 1'b1, 10, 0);
        add_vec(32'h0000_0050, 0, 1'b1, 7, 0);
        add_vec(32'h0000_0070, 12, 1'b0, 12, 0);
        add_vec(32'h0000_00F0, 0, 1'b1, 15, 0);
        add_vec(32'h0000_1000, 1, 1'b0, 1, 0);

        // Reset values while rst is held.
        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_req_addr", mem_req_addr, 32'd0);
        check("rst_fill_en", 32'(fill_en), 32'd0);
        check("rst_plru", 32'(plru), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_txn(vecs[i].addr, vecs[i].evict, vecs[i].exp_hit, vecs[i].exp_way, vecs[i].stall, 1'b0);
        end

        // Refill data arriving in IDLE is ignored.
        mem_rsp_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("idle_rsp_fill_en", 32'(fill_en), 32'd0);
            check("idle_rsp_req_ready", 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        mem_rsp_valid = 1'b0;

        // Reset in MISS_REQ: the refill request drops immediately.
        accept(32'h0000_2000, 4'd3, ok);
        @(posedge clk);
        #3;
        check("pre_rst_mem_req_valid", 32'(mem_req_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_miss_req_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_miss_req_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Refill a line, then reset in MISS_WAIT with refill data present; the line is gone afterwards.
        run_txn(32'h0000_00A0, 4'd2, 1'b0, 4'd2, 0, 1'b0);
        run_txn(32'h0000_00A0, 4'd0, 1'b1, 4'd2, 0, 1'b0);
        accept(32'h0000_3000, 4'd4, ok);
        @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_req_ready = 1'b0;
        #2;
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        #1;
        check("rst_wait_fill_en", 32'(fill_en), 32'd0);
        check("rst_wait_req_ready", 32'(req_ready), 32'd1);
        check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_fill_en", 32'(fill_en), 32'd0);
        @(posedge clk);
        #1;
        mem_rsp_valid = 1'b0;
        run_txn(32'h0000_00A0, 4'd6, 1'b0, 4'd6, 0, 1'b0);

`ifdef IFU_TAG_CTRL_FLUSH_EN
        // Flush in IDLE invalidates a resident line.
        run_txn(32'h0000_0040, 4'd4, 1'b0, 4'd4, 0, 1'b0);
        run_txn(32'h0000_0040, 4'd0, 1'b1, 4'd4, 0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        check("flush_idle_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        run_txn(32'h0000_0040, 4'd6, 1'b0, 4'd6, 0, 1'b0);

        // Flush during MISS_WAIT: the miss completes, then the flush lands before the next accept.
        run_txn(32'h0000_0090, 4'd1, 1'b0, 4'd1, 0, 1'b1);
        @(negedge clk);
        check("flush_pend_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        run_txn(32'h0000_0090, 4'd3, 1'b0, 4'd3, 0, 1'b0);
        run_txn(32'h0000_0040, 4'd8, 1'b0, 4'd8, 0, 1'b0);
`endif

        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifu_tag_ctrl.md
IFU_TAG_CTRL -- requirements
Module: ifu_tag_ctrl

Interface
REQ-001 WAYS_NUM, 16, number of ways; fully associative; equals the PLRU way count.
REQ-002 ADDR_W, 32, fetch address width.
REQ-003 OFFSET_W, 4, line offset bits; tag = addr[ADDR_W-1:OFFSET_W].
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  fetch request valid.
REQ-007 req_addr  input  ADDR_W  fetch byte address.
REQ-008 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-009 rsp_valid  output  1  one-cycle pulse: requested line resident in rsp_way.
REQ-010 rsp_way  output  log2(WAYS_NUM)  way holding the requested line.
REQ-011 mem_req_valid  output  1  line refill request.
REQ-012 mem_req_addr  output  ADDR_W  line-aligned refill address, low OFFSET_W bits zero.
REQ-013 mem_req_ready  input  1  memory accepts the refill request.
REQ-014 mem_rsp_valid  input  1  refill data present this cycle.
REQ-015 fill_en  output  1  data-array write strobe.
REQ-016 fill_way  output  log2(WAYS_NUM)  data-array write way.
REQ-017 cache_ctrl_plru  output  t_cache_ctrl_plru  fields update_tree, cache_miss, hit_cl to PLRU.
REQ-018 evicted_cl  input  log2(WAYS_NUM)  victim way from PLRU.

Function
REQ-019 The FSM SHALL have states IDLE, LOOKUP, MISS_REQ, MISS_WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 IDLE: on accept, latch req_addr tag; next state LOOKUP; else stay.
REQ-021 LOOKUP: compare the latched tag against all valid tags in parallel; at most one way SHALL match.
REQ-022 LOOKUP hit: rsp_valid=1, rsp_way=hit way, update_tree=1, cache_miss=0, hit_cl=hit way; next state IDLE; hit latency is exactly 1 cycle after accept.
REQ-023 LOOKUP miss: update_tree=1, cache_miss=1, hit_cl=0; capture evicted_cl into victim register; clear the victim's valid bit; next state MISS_REQ.
REQ-024 evicted_cl SHALL be sampled only in the LOOKUP-miss cycle.
REQ-025 update_tree SHALL be asserted only in LOOKUP, exactly once per accepted request.
REQ-026 MISS_REQ: mem_req_valid=1, mem_req_addr={tag, OFFSET_W'b0}, both held stable until mem_req_ready; on ready, next state MISS_WAIT.
REQ-027 MISS_WAIT: on mem_rsp_valid, fill_en=1, fill_way=victim, write tag, set valid; next state RESP.
REQ-028 RESP: rsp_valid=1, rsp_way=victim; next state IDLE.
REQ-029 mem_rsp_valid outside MISS_WAIT SHALL be ignored: no fill_en, no state change.
REQ-030 A valid victim with a different tag SHALL be overwritten; no writeback (instruction cache, read-only).
REQ-031 All outputs not listed for a state SHALL be 0.

Reset
REQ-032 rst SHALL asynchronously force IDLE, clear all valid bits, tags and the victim register, and drive every output to 0 except req_ready=1.
REQ-033 Reset mid-miss SHALL abandon the refill; mem_req_valid drops immediately, and a later mem_rsp_valid is ignored per REQ-029.

Configuration
REQ-034 With IFU_TAG_CTRL_FLUSH_EN defined, input flush (1 bit) SHALL be present. Flush in IDLE clears all valid bits at the next edge, with req_ready=0 that cycle. Flush in any other state sets a sticky pending flag. The in-flight miss completes, and the pending flush is applied on return to IDLE before the next request is accepted.
REQ-035 Without IFU_TAG_CTRL_FLUSH_EN, there SHALL be no flush port; valid bits clear only on rst.

Verification
REQ-036 After reset, request 0x0000_1000 with evicted_cl=0. Required response:
- mem_req_addr=0x0000_1000, then fill_way=0, then rsp_way=0.
- The same address again gives rsp_valid 1 cycle after accept, rsp_way=0, hit_cl=0, cache_miss=0.
REQ-037 Request 17 distinct lines 0x000,0x010..0x100, driving evicted_cl=i for i=0..15 and evicted_cl=5 for the 17th. Required response:
- fill_way tracks evicted_cl.
- Re-requesting 0x050 misses; 0x100 hits in way 5.
REQ-038 Hold mem_req_ready=0 for 5 cycles in MISS_REQ -> mem_req_valid=1 and mem_req_addr unchanged throughout, req_ready=0.
REQ-039 Pulse mem_rsp_valid in IDLE and in MISS_REQ -> fill_en stays 0, state unchanged.
REQ-040 Assert rst during MISS_WAIT -> outputs reset the same cycle; a re-request of a previously filled line misses.
REQ-041 (IFU_TAG_CTRL_FLUSH_EN) Run two cases:
- Fill 0x40, pulse flush in IDLE, request 0x40 -> miss.
- Pulse flush in MISS_WAIT -> RESP still occurs, then all valid bits clear before the next accept.
